// File: rtl/nwrite_hello_gen.sv
// rtl/nwrite_hello_gen.sv - Frames a raw payload stream into SRIO HELLO-format NWRITE requests
module nwrite_hello_gen #(
  parameter logic [15:0] SRC_ID    = 16'h0001,
  parameter logic [15:0] DEST_ID   = 16'h00FF,
  parameter logic [33:0] BASE_ADDR = 34'h0,
  parameter int unsigned MAX_BEATS = 32
) (
  input  logic        clk_rapid,
  input  logic        reset_rapid_n,
  input  logic [63:0] rapid_data_in,
  input  logic [7:0]  rapid_keep_in,
  input  logic        rapid_valid_in,
  input  logic        rapid_first_in,
  input  logic        rapid_last_in,
  input  logic [15:0] rapid_length_in,
  output logic        rapid_ready_out,
  output logic [63:0] ireq_tdata,
  output logic [7:0]  ireq_tkeep,
  output logic        ireq_tvalid,
  output logic        ireq_tlast,
  output logic [31:0] ireq_tuser,
  input  logic        ireq_tready,
  output logic        err_drop_out
);

  // Largest byte count a single NWRITE may carry.
  localparam logic [15:0] MAX_SEG = 16'(MAX_BEATS * 8);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_DISCARD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tid_q, tid_d;
  logic [33:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] segb_q, segb_d;
  logic        err_q, err_d;

  logic [15:0] seg_bytes;
  logic [7:0]  seg_size;
  logic [15:0] seg_beats;
  logic        seg_end;
  logic        ready_c;

  // Current segment geometry, derived from the bytes still owed for this frame.
  assign seg_bytes = (rem_q > MAX_SEG) ? MAX_SEG : rem_q;
  assign seg_size  = 8'(seg_bytes - 16'd1);
  assign seg_beats = (seg_bytes + 16'd7) >> 3;
  assign seg_end   = (cnt_q + 16'd1) == segb_q;

  assign ireq_tuser      = {SRC_ID, DEST_ID};
  assign err_drop_out    = err_q;
  // Reset must hold ready low even while an idle stray beat would be dropped.
  assign rapid_ready_out = reset_rapid_n & ready_c;

  // State and framing counters.
  always_ff @(posedge clk_rapid or negedge reset_rapid_n) begin
    if (!reset_rapid_n) begin
      state_q <= S_IDLE;
      tid_q   <= 8'd0;
      addr_q  <= BASE_ADDR;
      rem_q   <= 16'd0;
      cnt_q   <= 16'd0;
      segb_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      segb_q  <= segb_d;
      err_q   <= err_d;
    end
  end

  // Next-state, stream muxing and error detection.
  always_comb begin
    state_d     = state_q;
    tid_d       = tid_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    segb_d      = segb_q;
    err_d       = 1'b0;
    ready_c     = 1'b0;
    ireq_tvalid = 1'b0;
    ireq_tdata  = 64'd0;
    ireq_tkeep  = 8'd0;
    ireq_tlast  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rapid_valid_in) begin
          if (rapid_first_in) begin
            // The first beat stays on the input until DATA passes it through.
            rem_d = rapid_length_in;
            if (rapid_length_in != 16'd0) begin
              state_d = S_HEADER;
            end else begin
              state_d = S_DISCARD;
              err_d   = 1'b1;
            end
          end else begin
            ready_c = 1'b1;
          end
        end
      end
      S_HEADER: begin
        ireq_tvalid = 1'b1;
        ireq_tkeep  = 8'hFF;
        ireq_tdata  = {tid_q, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, seg_size, 2'b00, addr_q};
        if (ireq_tready) begin
          state_d = S_DATA;
          tid_d   = tid_q + 8'd1;
          addr_d  = addr_q + {18'd0, seg_bytes};
          rem_d   = rem_q - seg_bytes;
          segb_d  = seg_beats;
          cnt_d   = 16'd0;
        end
      end
      S_DATA: begin
        ireq_tvalid = rapid_valid_in;
        ireq_tdata  = rapid_data_in;
        ireq_tkeep  = rapid_keep_in;
        ireq_tlast  = seg_end | rapid_last_in;
        ready_c     = ireq_tready;
        if (rapid_valid_in && ireq_tready) begin
          if (rapid_last_in) begin
            // Frame ends here; only a clean end of the final segment is error-free.
            state_d = S_IDLE;
            err_d   = !(seg_end && (rem_q == 16'd0));
          end else if (seg_end) begin
            if (rem_q != 16'd0) begin
              state_d = S_HEADER;
            end else begin
              state_d = S_DISCARD;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DISCARD: begin
        ready_c = 1'b1;
        if (rapid_valid_in && rapid_last_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nwrite_hello_gen.sv
// tb/tb_nwrite_hello_gen.sv - Self-checking bench for nwrite_hello_gen
module tb_nwrite_hello_gen;

  localparam int          MAXB = 32;
  localparam logic [33:0] BASE = 34'h0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk_rapid = 1'b0;
  logic        reset_rapid_n = 1'b0;
  logic [63:0] rapid_data_in = 64'd0;
  logic [7:0]  rapid_keep_in = 8'd0;
  logic        rapid_valid_in = 1'b0;
  logic        rapid_first_in = 1'b0;
  logic        rapid_last_in = 1'b0;
  logic [15:0] rapid_length_in = 16'd0;
  logic        rapid_ready_out;
  logic [63:0] ireq_tdata;
  logic [7:0]  ireq_tkeep;
  logic        ireq_tvalid;
  logic        ireq_tlast;
  logic [31:0] ireq_tuser;
  logic        ireq_tready = 1'b1;
  logic        err_drop_out;

  nwrite_hello_gen dut (
    .clk_rapid       (clk_rapid),
    .reset_rapid_n   (reset_rapid_n),
    .rapid_data_in   (rapid_data_in),
    .rapid_keep_in   (rapid_keep_in),
    .rapid_valid_in  (rapid_valid_in),
    .rapid_first_in  (rapid_first_in),
    .rapid_last_in   (rapid_last_in),
    .rapid_length_in (rapid_length_in),
    .rapid_ready_out (rapid_ready_out),
    .ireq_tdata      (ireq_tdata),
    .ireq_tkeep      (ireq_tkeep),
    .ireq_tvalid     (ireq_tvalid),
    .ireq_tlast      (ireq_tlast),
    .ireq_tuser      (ireq_tuser),
    .ireq_tready     (ireq_tready),
    .err_drop_out    (err_drop_out)
  );

  always #5 clk_rapid = ~clk_rapid;

  int          n_checks = 0;
  int          n_fail = 0;
  beat_t       exp_q[$];
  logic [63:0] hdr_log[$];
  int          err_seen = 0;
  int          obs_beats = 0;
  int          obs_last = 0;
  bit          toggle_mode = 1'b0;
  logic [7:0]  m_tid = 8'd0;
  logic [33:0] m_addr = BASE;
  int          exp_err = 0;
  logic [63:0] fd[128];
  logic [7:0]  fk[128];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected output stream of one frame: headers and payload beats by segment arithmetic.
  task automatic model_frame(input int len, input int n, input int lidx);
    int rem;
    int idx;
    int seg;
    int sb;
    bit done;
    bit lastin;
    beat_t b;
    rem = len;
    idx = 0;
    done = 1'b0;
    for (int i = 0; i < n; i++) begin
      fd[i] = {$urandom, $urandom};
      fk[i] = (i == lidx) ? 8'h0F : 8'hFF;
    end
    if (len == 0) begin
      exp_err++;
      return;
    end
    while (!done) begin
      seg = (rem > MAXB * 8) ? MAXB * 8 : rem;
      b.d = {m_tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, 8'(seg - 1), 2'b00, m_addr};
      b.k = 8'hFF;
      b.l = 1'b0;
      exp_q.push_back(b);
      m_tid  = m_tid + 8'd1;
      m_addr = m_addr + 34'(seg);
      rem    = rem - seg;
      sb     = (seg + 7) / 8;
      for (int k = 1; k <= sb && !done; k++) begin
        lastin = (idx == lidx);
        b.d = fd[idx];
        b.k = fk[idx];
        b.l = (k == sb) || lastin;
        exp_q.push_back(b);
        idx++;
        if (lastin) begin
          if (k < sb || rem != 0) exp_err++;
          done = 1'b1;
        end else if (k == sb && rem == 0) begin
          exp_err++;
          done = 1'b1;
        end
      end
    end
  endtask

  // Downstream ready: steady high, or alternating each cycle for stall tests.
  initial begin
    forever begin
      @(posedge clk_rapid);
      #1;
      ireq_tready = toggle_mode ? ~ireq_tready : 1'b1;
    end
  end

  // Single compare process: every accepted output beat against the model, plus stall hold.
  bit          stall_prev = 1'b0;
  bit          expect_hdr = 1'b1;
  logic [63:0] prev_d;
  logic [9:0]  prev_ctl;
  always @(negedge clk_rapid) begin
    if (!reset_rapid_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
      expect_hdr = 1'b1;
    end else begin
      if (stall_prev) begin
        chk("stall_data", ireq_tdata, prev_d);
        chk("stall_ctl", {54'd0, ireq_tvalid, ireq_tlast, ireq_tkeep}, {54'd0, prev_ctl});
      end
      if (ireq_tvalid && ireq_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat", ireq_tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", ireq_tdata, e.d);
          chk("beat_keep_last", {55'd0, ireq_tkeep, ireq_tlast}, {55'd0, e.k, e.l});
        end
        if (expect_hdr) hdr_log.push_back(ireq_tdata);
        expect_hdr = ireq_tlast;
        obs_beats++;
        if (ireq_tlast) obs_last++;
      end
      stall_prev = ireq_tvalid && !ireq_tready;
      prev_d     = ireq_tdata;
      prev_ctl   = {ireq_tvalid, ireq_tlast, ireq_tkeep};
      if (err_drop_out) err_seen++;
    end
  end

  task automatic wait_accept(output bit acc);
    int t;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 400) begin
      @(negedge clk_rapid);
      acc = rapid_ready_out;
      @(posedge clk_rapid);
      #1;
      t++;
    end
  endtask

  task automatic send_frame(input int len, input int n, input int lidx, input int rst_at);
    bit acc;
    for (int i = 0; i < n; i++) begin
      rapid_valid_in  = 1'b1;
      rapid_data_in   = fd[i];
      rapid_keep_in   = fk[i];
      rapid_first_in  = (i == 0);
      rapid_last_in   = (i == lidx);
      rapid_length_in = 16'(len);
      if (i == rst_at) begin
        #2;
        chk("pre_reset_tvalid", {63'd0, ireq_tvalid}, 64'd1);
        reset_rapid_n = 1'b0;
        m_tid  = 8'd0;
        m_addr = BASE;
        #1;
        chk("rst_tvalid", {63'd0, ireq_tvalid}, 64'd0);
        chk("rst_tdata", ireq_tdata, 64'd0);
        chk("rst_tkeep_tlast", {55'd0, ireq_tkeep, ireq_tlast}, 64'd0);
        chk("rst_ready_err", {62'd0, rapid_ready_out, err_drop_out}, 64'd0);
        rapid_valid_in = 1'b0;
        rapid_first_in = 1'b0;
        rapid_last_in  = 1'b0;
        repeat (2) @(posedge clk_rapid);
        #1;
        reset_rapid_n = 1'b1;
        return;
      end
      wait_accept(acc);
      chk("beat_accepted", {63'd0, acc}, 64'd1);
      if (!acc) break;
    end
    rapid_valid_in = 1'b0;
    rapid_first_in = 1'b0;
    rapid_last_in  = 1'b0;
  endtask

  task automatic run(input string name, input int len, input int n, input int lidx, input int rst_at);
    int base_err;
    int t;
    base_err = err_seen;
    exp_err  = 0;
    model_frame(len, n, lidx);
    send_frame(len, n, lidx, rst_at);
    if (rst_at < 0) begin
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
        @(posedge clk_rapid);
        t++;
      end
      chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    end
    repeat (3) @(posedge clk_rapid);
    #1;
    chk({name, "_err_pulses"}, 64'(err_seen - base_err), 64'(exp_err));
  endtask

  initial begin
    int  e0;
    bit  acc;
    repeat (3) @(posedge clk_rapid);
    #1;
    chk("reset_tvalid_tlast", {62'd0, ireq_tvalid, ireq_tlast}, 64'd0);
    chk("reset_tdata", ireq_tdata, 64'd0);
    chk("reset_tkeep", {56'd0, ireq_tkeep}, 64'd0);
    chk("reset_ready_err", {62'd0, rapid_ready_out, err_drop_out}, 64'd0);
    chk("tuser", {32'd0, ireq_tuser}, 64'h0000_0000_0001_00FF);
    reset_rapid_n = 1'b1;
    @(posedge clk_rapid);
    #1;

    hdr_log.delete();
    run("t1_len64", 64, 8, 7, -1);
    run("t1b_len8", 8, 1, 0, -1);
    chk("t1_hdr", hdr_log[0], 64'h0054_23F0_0000_0000);
    chk("t1b_hdr", hdr_log[1], 64'h0154_2070_0000_0040);

    reset_rapid_n = 1'b0;
    m_tid  = 8'd0;
    m_addr = BASE;
    repeat (2) @(posedge clk_rapid);
    #1;
    reset_rapid_n = 1'b1;
    @(posedge clk_rapid);
    #1;
    hdr_log.delete();
    obs_beats = 0;
    obs_last  = 0;
    run("t2_len600", 600, 75, 74, -1);
    chk("t2_hdr0", hdr_log[0], 64'h0054_2FF0_0000_0000);
    chk("t2_hdr1", hdr_log[1], 64'h0154_2FF0_0000_0100);
    chk("t2_hdr2", hdr_log[2], 64'h0254_2570_0000_0200);
    chk("t2_beats", 64'(obs_beats), 64'd78);
    chk("t2_lasts", 64'(obs_last), 64'd3);

    obs_last = 0;
    e0 = err_seen;
    run("t3_early_last", 64, 5, 4, -1);
    chk("t3_err_lit", 64'(err_seen - e0), 64'd1);
    chk("t3_lasts", 64'(obs_last), 64'd1);

    obs_beats = 0;
    e0 = err_seen;
    run("t4_len0", 0, 3, 2, -1);
    chk("t4_no_output", 64'(obs_beats), 64'd0);
    chk("t4_err_lit", 64'(err_seen - e0), 64'd1);

    e0 = err_seen;
    rapid_valid_in = 1'b1;
    rapid_first_in = 1'b0;
    rapid_last_in  = 1'b1;
    rapid_data_in  = 64'hDEAD_BEEF_0000_1111;
    wait_accept(acc);
    rapid_valid_in = 1'b0;
    rapid_last_in  = 1'b0;
    repeat (3) @(posedge clk_rapid);
    #1;
    chk("t5_stray_accepted", {63'd0, acc}, 64'd1);
    chk("t5_stray_no_err", 64'(err_seen - e0), 64'd0);
    chk("t5_stray_no_output", 64'(obs_beats), 64'd0);

    toggle_mode = 1'b1;
    run("t6_stall", 64, 8, 7, -1);
    toggle_mode = 1'b0;

    run("t9_overrun", 8, 2, 1, -1);

    run("t7_reset", 128, 16, 15, 4);
    @(posedge clk_rapid);
    #1;
    hdr_log.delete();
    run("t8_after_reset", 16, 2, 1, -1);
    chk("t8_hdr", hdr_log[0], 64'h0054_20F0_0000_0000);
    chk("tuser_end", {32'd0, ireq_tuser}, 64'h0000_0000_0001_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
